// File: rtl/intpol2_d4_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : intpol2_d4_out_fifo
//  Function : First-word-fall-through output FIFO for the interpolator
//             datapath. Has an almost-full stall request, a sticky overflow
//             flag and an optional dropped-write counter.
//  Options  : INTPOL2_D4_OUT_FIFO_DROP_CNT_EN - when this macro is defined,
//             drop_cnt counts dropped writes and saturates at 16'hFFFF.
//             When it is undefined, drop_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module intpol2_d4_out_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_MARGIN  = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          clear,
   input  logic                          Ld_data,
   input  logic [DATA_WIDTH-1:0]         data_in,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic                          full,
   output logic                          almost_full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic [15:0]                   drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_L  = PW'(FIFO_DEPTH);
   localparam logic [PW-1:0] MARGIN_L = PW'(AF_MARGIN);
   localparam logic [PW-1:0] ONE_L    = PW'(1);

   // Storage holds no reset value, so it can map onto plain RAM.
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   // The pointers are one bit wider than the address. The extra MSB tells
   // a full FIFO apart from an empty one.
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] level_q;

   logic do_read;
   logic do_write;
   logic do_drop;

   // Handshake decode. When the FIFO is full, a read in the same cycle
   // frees the slot that the new write fills.
   always_comb begin
      do_read  = m_valid & m_ready;
      do_write = Ld_data & (~full | do_read);
      do_drop  = Ld_data & ~do_write;
   end

   assign level       = level_q;
   assign m_valid     = (level_q != '0);
   assign full        = (level_q == DEPTH_L);
   assign almost_full = ((DEPTH_L - level_q) <= MARGIN_L);
   assign m_data      = mem[rptr[AW-1:0]];

   // Write port of the sample memory. It has no reset, and clear does not
   // scrub it.
   always_ff @(posedge clk) begin
      if (rstn && !clear && do_write) begin
         mem[wptr[AW-1:0]] <= data_in;
      end
   end

   // Pointer and occupancy tracking. rstn has priority over clear, and
   // clear has priority over traffic in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         wptr    <= '0;
         rptr    <= '0;
         level_q <= '0;
      end else begin
         if (do_write) begin
            wptr <= wptr + ONE_L;
         end
         if (do_read) begin
            rptr <= rptr + ONE_L;
         end
         if (do_write && !do_read) begin
            level_q <= level_q + ONE_L;
         end else if (do_read && !do_write) begin
            level_q <= level_q - ONE_L;
         end
      end
   end

   // Sticky flag: stays set after any write is lost, until clear or reset.
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         overflow <= 1'b0;
      end else if (do_drop) begin
         overflow <= 1'b1;
      end
   end

`ifdef INTPOL2_D4_OUT_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   // Count of dropped writes. The count holds once it reaches all-ones.
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         drop_cnt_q <= 16'd0;
      end else if (do_drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_intpol2_d4_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intpol2_d4_out_fifo
//  Function : Self-checking bench for intpol2_d4_out_fifo. Compares the DUT
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_intpol2_d4_out_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AF    = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          clear = 1'b0;
   logic          Ld_data = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          full;
   logic          almost_full;
   logic [4:0]    level;
   logic          overflow;
   logic [15:0]   drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a queue of stored samples, plus the flag and the count.
   logic [DW-1:0] mq[$];
   logic          m_ovf   = 1'b0;
   logic [15:0]   m_drops = 16'd0;

   intpol2_d4_out_fifo #(
      .DATA_WIDTH(DW),
      .FIFO_DEPTH(DEPTH),
      .AF_MARGIN (AF)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .clear      (clear),
      .Ld_data    (Ld_data),
      .data_in    (data_in),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .full       (full),
      .almost_full(almost_full),
      .level      (level),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_drops();
`ifdef INTPOL2_D4_OUT_FIFO_DROP_CNT_EN
      return m_drops;
`else
      return 16'd0;
`endif
   endfunction

   // Drive one clock cycle of stimulus and advance the model to match.
   // On return, time is 1 unit after the rising edge and the inputs are idle.
   task automatic cycle(input logic ld, input logic [DW-1:0] d, input logic rdy,
                        input logic clr, input logic rst_n);
      bit rd;
      bit wr;
      Ld_data = ld;
      data_in = d;
      m_ready = rdy;
      clear   = clr;
      rstn    = rst_n;
      rd = (mq.size() != 0) && rdy;
      wr = ld && ((mq.size() < DEPTH) || rd);
      @(posedge clk);
      #1;
      if (!rst_n || clr) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_drops = 16'd0;
      end else begin
         if (rd) void'(mq.pop_front());
         if (wr) mq.push_back(d);
         if (ld && !wr) begin
            m_ovf = 1'b1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
         end
      end
      Ld_data = 1'b0;
      m_ready = 1'b0;
      clear   = 1'b0;
      rstn    = 1'b1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (level !== 5'd0 || m_valid !== 1'b0 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a: level=%0d m_valid=%b full=%b, expected 0 0 0", level, m_valid, full);
      end
      n_tests++;
      if (almost_full !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_b: af=%b ovf=%b drop=%0d, expected 0 0 0", almost_full, overflow, drop_cnt);
      end
   endtask

   task automatic test_basic();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (level !== 5'd3 || m_valid !== 1'b1 || m_data !== 32'h1) begin
         n_fail++;
         $display("FAIL basic_fill: level=%0d valid=%b data=%h, expected 3 1 00000001", level, m_valid, m_data);
      end
      for (int i = 1; i <= 3; i++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== DW'(i)) begin
            n_fail++;
            $display("FAIL basic_out%0d: valid=%b data=%h, expected 1 %h", i, m_valid, m_data, DW'(i));
         end
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      end
      n_tests++;
      if (m_valid !== 1'b0 || level !== 5'd0) begin
         n_fail++;
         $display("FAIL basic_empty: valid=%b level=%0d, expected 0 0", m_valid, level);
      end
   endtask

   task automatic test_fill_overflow();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0, 1'b1);
         n_tests++;
         if (level !== 5'(i + 1) || almost_full !== ((i + 1) >= 14) || full !== ((i + 1) == DEPTH)) begin
            n_fail++;
            $display("FAIL fill_lvl%0d: level=%0d af=%b full=%b, expected %0d %b %b",
                     i + 1, level, almost_full, full, i + 1, ((i + 1) >= 14), ((i + 1) == DEPTH));
         end
      end
      cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== exp_drops()) begin
         n_fail++;
         $display("FAIL overflow: level=%0d ovf=%b drop=%0d, expected 16 1 %0d", level, overflow, drop_cnt, exp_drops());
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== 32'h100 + DW'(i)) begin
            n_fail++;
            $display("FAIL drain%0d: valid=%b data=%h, expected 1 %h", i, m_valid, m_data, 32'h100 + DW'(i));
         end
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      end
      n_tests++;
      if (m_valid !== 1'b0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_end: valid=%b ovf=%b, expected 0 1", m_valid, overflow);
      end
   endtask

   task automatic test_full_rw();
      logic [DW-1:0] last;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (m_data !== mq[0] || full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_pre: data=%h full=%b, expected %h 1", m_data, full, mq[0]);
      end
      cycle(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
      n_tests++;
      if (level !== 5'd16 || overflow !== 1'b0 || m_data !== mq[0]) begin
         n_fail++;
         $display("FAIL full_rw: level=%0d ovf=%b data=%h, expected 16 0 %h", level, overflow, m_data, mq[0]);
      end
      last = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== mq[0]) begin
            n_fail++;
            $display("FAIL full_drain%0d: valid=%b data=%h, expected 1 %h", i, m_valid, m_data, mq[0]);
         end
         last = m_data;
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      end
      n_tests++;
      if (last !== 32'h7FFF_FFFF) begin
         n_fail++;
         $display("FAIL full_last: got %h, expected 7fffffff", last);
      end
   endtask

   task automatic test_stream();
      logic [DW-1:0] sent[$];
      logic [DW-1:0] got[$];
      int bad_lvl;
      bad_lvl = 0;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         logic [DW-1:0] d;
         d = DW'($urandom);
         sent.push_back(d);
         if (m_valid === 1'b1) got.push_back(m_data);
         cycle(1'b1, d, 1'b1, 1'b0, 1'b1);
         if (level > 5'd1) bad_lvl++;
      end
      while (m_valid === 1'b1 && got.size() < 40) begin
         got.push_back(m_data);
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      end
      n_tests++;
      if (bad_lvl != 0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_lvl: level>1 count=%0d ovf=%b, expected 0 0", bad_lvl, overflow);
      end
      n_tests++;
      if (got.size() != 40 || got != sent) begin
         n_fail++;
         $display("FAIL stream_seq: got %0d samples (first %h), expected 40 matching (first %h)",
                  got.size(), (got.size() != 0) ? got[0] : 32'h0, sent[0]);
      end
   endtask

   task automatic test_clear_reset();
      for (int pass = 0; pass < 2; pass++) begin
         cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
         n_tests++;
         if (level !== 5'd5 || overflow !== 1'b1 || drop_cnt !== exp_drops()) begin
            n_fail++;
            $display("FAIL flush_pre%0d: level=%0d ovf=%b drop=%0d, expected 5 1 %0d",
                     pass, level, overflow, drop_cnt, exp_drops());
         end
         if (pass == 0) cycle(1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1);
         else           cycle(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
         n_tests++;
         if (level !== 5'd0 || m_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL flush%0d: level=%0d valid=%b ovf=%b drop=%0d, expected 0 0 0 0",
                     pass, level, m_valid, overflow, drop_cnt);
         end
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         int wr_pct;
         int rd_pct;
         wr_pct = ((i / 100) % 2 == 0) ? 75 : 30;
         rd_pct = ((i / 100) % 2 == 0) ? 30 : 75;
         n_tests++;
         if (level !== 5'(mq.size()) || m_valid !== (mq.size() != 0) ||
             full !== (mq.size() == DEPTH) || almost_full !== ((DEPTH - mq.size()) <= AF) ||
             overflow !== m_ovf || drop_cnt !== exp_drops() ||
             (mq.size() != 0 && m_data !== mq[0])) begin
            n_fail++;
            errs++;
            if (errs <= 5)
               $display("FAIL rand_c%0d: level=%0d valid=%b full=%b af=%b ovf=%b drop=%0d data=%h, expected level=%0d ovf=%b drop=%0d data=%h",
                        i, level, m_valid, full, almost_full, overflow, drop_cnt, m_data,
                        mq.size(), m_ovf, exp_drops(), (mq.size() != 0) ? mq[0] : 32'h0);
         end
         cycle($urandom_range(99) < wr_pct, DW'($urandom), $urandom_range(99) < rd_pct,
               $urandom_range(149) == 0, $urandom_range(299) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_full_rw();
      test_stream();
      test_clear_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/intpol2_d4_out_fifo.md
INTPOL2_D4_OUT_FIFO -- requirements
Module: intpol2_d4_out_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each interpolated sample.
REQ-002 Parameter FIFO_DEPTH, default 16: number of storage entries; SHALL be a power of two, minimum 4.
REQ-003 Parameter AF_MARGIN, default 2: almost_full asserts when free entries <= AF_MARGIN.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 clear  input  1  synchronous flush, active-high.
REQ-007 Ld_data  input  1  write strobe from the interpolator datapath; one sample per asserted cycle.
REQ-008 data_in  input  DATA_WIDTH  signed sample; valid when Ld_data=1.
REQ-009 m_valid  output  1  output sample available.
REQ-010 m_ready  input  1  downstream consumer accepts the sample.
REQ-011 m_data  output  DATA_WIDTH  oldest stored sample.
REQ-012 full  output  1  level == FIFO_DEPTH.
REQ-013 almost_full  output  1  stall request to the interpolator controller.
REQ-014 level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky: a write was dropped.
REQ-016 drop_cnt  output  16  dropped-write count; see Configuration.

Function
REQ-017 Write pointer and read pointer SHALL each be $clog2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH; the MSB distinguishes full from empty.
REQ-018 A write is accepted when Ld_data=1 and (full=0 or a read occurs in the same cycle); the sample is stored at wptr and wptr increments.
REQ-019 A read occurs when m_valid=1 and m_ready=1; rptr increments.
REQ-020 FIFO SHALL be first-word-fall-through: m_data SHALL equal mem[rptr] whenever m_valid=1; m_valid = (level != 0).
REQ-021 Latency: a sample written into an empty FIFO at edge t SHALL appear on m_valid/m_data after edge t (visible in cycle t+1).
REQ-022 level SHALL increment on write-only, decrement on read-only, and stay unchanged on simultaneous accepted read and write, including when full and when level==1.
REQ-023 Ld_data=1 while full=1 with no read in the same cycle: data is dropped, pointers and level are unchanged, overflow is set to 1.
REQ-024 m_ready=1 while empty: no effect; rptr and level are unchanged.
REQ-025 almost_full = (FIFO_DEPTH - level) <= AF_MARGIN; full and almost_full are combinational from level.
REQ-026 m_data SHALL be undefined-safe while m_valid=0; the bench must not check it.
REQ-027 clear=1 SHALL zero wptr, rptr, level, overflow and drop_cnt at the next edge, with priority over a simultaneous write and read in that cycle; memory contents are not cleared.
REQ-028 Data SHALL pass bit-exact; no sign extension, truncation or reordering.

Reset
REQ-029 rstn=0 at a rising edge SHALL set wptr=0, rptr=0, level=0, overflow=0, drop_cnt=0; m_valid=0, full=0, almost_full=0 after that edge.
REQ-030 Reset mid-operation SHALL discard all stored samples, and writes in the reset cycle are ignored; rstn has priority over clear.
REQ-031 Storage memory has no reset.

Configuration
REQ-032 Macro INTPOL2_D4_OUT_FIFO_DROP_CNT_EN defined: drop_cnt increments on every dropped write (REQ-023) and saturates at 16'hFFFF.
REQ-033 Macro undefined: drop_cnt SHALL be tied to 0 and no counter logic is synthesized; all other behaviour is identical.

Verification
REQ-034 Reset, then write 0x00000001..0x00000003 on consecutive cycles with m_ready=0 -> level=3, m_valid=1, m_data=0x00000001; then m_ready=1 -> outputs 1,2,3 in order, then m_valid=0.
REQ-035 Fill 16 entries with m_ready=0 -> full=1 and almost_full asserted from level 14; a 17th write of 0xDEADBEEF -> dropped, overflow=1, drop_cnt=1 (macro on) or 0 (macro off), last output still the 16th sample.
REQ-036 While full, Ld_data=1 and m_ready=1 in the same cycle with data 0x7FFFFFFF -> level stays 16, the oldest sample is read, and 0x7FFFFFFF is eventually output last.
REQ-037 Continuous Ld_data and m_ready for 40 cycles -> pointer wrap occurs twice, output sequence equals the input sequence, level stays <= 1, and overflow=0.
REQ-038 With level=5, assert clear together with Ld_data -> next cycle level=0, m_valid=0, overflow=0; repeat with rstn=0 instead of clear -> same result.
